ioctl_upload_server: RTL and testbench

//  Host-side upload responder: the read-back counterpart of the ioctl download path into system.

---
 rtl/ioctl_upload_server.sv | 146 ++++++++++++++
 tb/tb_ioctl_upload_server.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_server.sv
// Host ioctl upload responder: fetches bytes from a fixed-latency memory port and returns them on ioctl_din.
// Optional UPLOAD_CHECKSUM_EN adds a running mod-256 checksum of delivered bytes on upload_csum.
module ioctl_upload_server #(
  parameter int          ADDR_W       = 17,
  parameter int          MEM_BYTES    = 131072,
  parameter int          RD_LATENCY   = 1,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd2,
  parameter logic [7:0]  FILL_BYTE    = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_index,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              upload_active,
`ifdef UPLOAD_CHECKSUM_EN
  output logic [7:0]        upload_csum,
`endif
  output logic [24:0]       bytes_sent
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  localparam logic [24:0] LP_MEM_BYTES = 25'(MEM_BYTES);
  // cnt is 1 in the strobe cycle; data lands RD_LATENCY cycles after that
  localparam logic [3:0]  LP_CNT_LAST  = 4'(RD_LATENCY + 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [7:0]        r_din;
  logic              r_wait;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_active;
  logic              r_active_d;
  logic [24:0]       r_bytes;

  logic        w_sel;
  logic        w_accept;
  logic        w_in_range;
  logic        w_clr;
  logic [24:0] w_bytes_base;
  logic [24:0] w_bytes_inc;

  assign w_sel        = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign w_accept     = (r_state == S_IDLE) && ioctl_rd && w_sel;
  assign w_in_range   = ioctl_addr < LP_MEM_BYTES;
  assign w_clr        = r_active && !r_active_d;
  assign w_bytes_base = w_clr ? 25'd0 : r_bytes;
  assign w_bytes_inc  = (&w_bytes_base) ? w_bytes_base : w_bytes_base + 25'd1;

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] r_csum;
  logic [7:0] w_csum_base;
  assign w_csum_base = w_clr ? 8'd0 : r_csum;
  assign upload_csum = r_csum;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_din      <= 8'd0;
      r_wait     <= 1'b0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_active   <= 1'b0;
      r_active_d <= 1'b0;
      r_bytes    <= 25'd0;
`ifdef UPLOAD_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      r_active   <= w_sel;
      r_active_d <= r_active;
      r_bytes    <= w_bytes_base;
      r_mem_rd   <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      r_csum     <= w_csum_base;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wait <= 1'b1;
            if (w_in_range) begin
              r_mem_addr <= ioctl_addr[ADDR_W-1:0];
              r_mem_rd   <= 1'b1;
              r_cnt      <= 4'd1;
              r_state    <= S_FETCH;
            end else begin
              r_din   <= FILL_BYTE;
              r_state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          // losing the session wins over a completing fetch
          if (!ioctl_upload) begin
            r_wait  <= 1'b0;
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_din   <= mem_data;
            r_wait  <= 1'b0;
            r_bytes <= w_bytes_inc;
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
`ifdef UPLOAD_CHECKSUM_EN
            r_csum  <= w_csum_base + mem_data;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_wait  <= 1'b0;
          r_state <= S_IDLE;
          if (ioctl_upload) begin
            r_bytes <= w_bytes_inc;
`ifdef UPLOAD_CHECKSUM_EN
            r_csum  <= w_csum_base + FILL_BYTE;
`endif
          end
        end
        default: begin
          r_wait  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_din     = r_din;
  assign ioctl_wait    = r_wait;
  assign mem_addr      = r_mem_addr;
  assign mem_rd        = r_mem_rd;
  assign upload_active = r_active;
  assign bytes_sent    = r_bytes;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Bench for ioctl_upload_server: directed plus randomized requests against a byte-level reference model.
module tb_ioctl_upload_server;
  localparam int RL   = 2;
  localparam int MEMB = 131072;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_index = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [16:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        upload_active;
  logic [24:0] bytes_sent;
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]  upload_csum;
`endif

  ioctl_upload_server #(.ADDR_W(17), .MEM_BYTES(MEMB), .RD_LATENCY(RL),
                        .UPLOAD_INDEX(8'd2), .FILL_BYTE(8'hFF)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .upload_active(upload_active),
`ifdef UPLOAD_CHECKSUM_EN
    .upload_csum(upload_csum),
`endif
    .bytes_sent(bytes_sent));

  always #5 clk_sys = ~clk_sys;

  // memory: data for a strobe appears RL cycles later, garbage otherwise
  logic [7:0]  mem [0:MEMB-1];
  logic [16:0] pa [RL];
  logic        pv [RL];
  always @(posedge clk_sys) begin
    pv[0] <= mem_rd;
    pa[0] <= mem_addr;
    for (int k = 1; k < RL; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end
  always_comb begin
    mem_data = 8'h3C;
    if (pv[RL-1] === 1'b1) mem_data = mem[pa[RL-1]];
  end

  int n_chk = 0, n_pass = 0, tot_rd = 0, exp_rd = 0;
  logic [24:0] m_bytes = '0;
  logic [7:0]  m_din = '0, m_csum = '0;

  always @(negedge clk_sys) if (mem_rd === 1'b1) tot_rd++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic new_session();
    ioctl_upload = 1'b0; cyc(3);
    ioctl_upload = 1'b1; ioctl_index = 8'd2; cyc(3);
    m_bytes = '0; m_csum = '0;
    chk("session_clear", 32'(bytes_sent), 32'(m_bytes));
  endtask

  // one host read; the model decides acceptance, byte value and wait length from the rules
  task automatic req(input logic [24:0] a, input logic [7:0] idx, input bit poke);
    bit acc, inr;
    int wc, rdc;
    logic [7:0] b;
    acc = (ioctl_upload === 1'b1) && (idx == 8'd2);
    inr = a < 25'(MEMB);
    ioctl_addr = a; ioctl_index = idx; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    wc = 0; rdc = 0;
    while (ioctl_wait === 1'b1 && wc < 20) begin
      if (mem_rd === 1'b1) begin
        rdc++;
        chk("mem_addr", 32'(mem_addr), 32'(a[16:0]));
      end
      if (poke && wc == 0) ioctl_rd = 1'b1;
      @(negedge clk_sys); ioctl_rd = 1'b0; wc++;
    end
    if (acc) begin
      b = inr ? mem[a[16:0]] : 8'hFF;
      chk("wait_len", wc, inr ? RL + 1 : 1);
      chk("mem_rd_cnt", rdc, inr ? 1 : 0);
      chk("din", 32'(ioctl_din), 32'(b));
      m_din = b;
      if (m_bytes != '1) m_bytes++;
      m_csum = m_csum + b;
      if (inr) exp_rd++;
    end else begin
      chk("ign_wait", wc, 0);
      chk("ign_rd", rdc, 0);
      chk("ign_din", 32'(ioctl_din), 32'(m_din));
    end
    chk("bytes_sent", 32'(bytes_sent), 32'(m_bytes));
    chk("mem_rd_after", 32'(mem_rd), 0);
`ifdef UPLOAD_CHECKSUM_EN
    chk("csum", 32'(upload_csum), 32'(m_csum));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wc;
    logic [24:0] a;
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    mem[17'h123] = 8'hA5; mem[17'h200] = 8'h80; mem[17'h201] = 8'h90;
    for (int i = 0; i < 256; i++) mem[17'h1000 + i] = 8'(i);

    // reset
    reset_n = 1'b0; cyc(3);
    chk("rst_din", 32'(ioctl_din), 0); chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_addr", 32'(mem_addr), 0); chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_act", 32'(upload_active), 0); chk("rst_bytes", 32'(bytes_sent), 0);
    reset_n = 1'b1; cyc(5);
    chk("idle_din", 32'(ioctl_din), 0); chk("idle_wait", 32'(ioctl_wait), 0);
    chk("idle_rd", 32'(mem_rd), 0); chk("idle_bytes", 32'(bytes_sent), 0);

    // basic in-range and out-of-range reads
    ioctl_upload = 1'b1; ioctl_index = 8'd2; cyc(3);
    chk("active", 32'(upload_active), 1);
    req(25'h0000123, 8'd2, 1'b0);
    req(25'h0020000, 8'd2, 1'b0);

    // wrong index ignored; restoring it starts a new session
    req(25'h0000123, 8'd3, 1'b0);
    ioctl_index = 8'd2; cyc(3); m_bytes = '0; m_csum = '0;
    chk("reselect_clear", 32'(bytes_sent), 0);
    req(25'h0000456, 8'd2, 1'b1);
    req(25'h0020001, 8'd2, 1'b1);

    // randomized traffic with back-to-back and gapped requests
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 25'(MEMB + $urandom_range(0, 4095))
                                      : 25'($urandom_range(0, MEMB - 1));
      req(a, 8'd2, $urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 2));
    end

    // abort during fetch
    ioctl_addr = 25'h0000456; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    chk("abort_rd", 32'(mem_rd), 1); exp_rd++;
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_wait", 32'(ioctl_wait), 0); chk("abort_rd_low", 32'(mem_rd), 0);
    chk("abort_din", 32'(ioctl_din), 32'(m_din)); chk("abort_bytes", 32'(bytes_sent), 32'(m_bytes));
    cyc(3);
    chk("held_bytes", 32'(bytes_sent), 32'(m_bytes)); chk("inactive", 32'(upload_active), 0);
    new_session();

    // abort during out-of-range reply
    ioctl_addr = 25'h1FFFFFF; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    m_din = 8'hFF;
    chk("abortd_wait", 32'(ioctl_wait), 0); chk("abortd_din", 32'(ioctl_din), 32'(m_din));
    chk("abortd_bytes", 32'(bytes_sent), 32'(m_bytes));
    new_session();

    // index change mid-fetch does not abort
    ioctl_addr = 25'h0000123; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0; ioctl_index = 8'd5;
    wc = 0;
    while (ioctl_wait === 1'b1 && wc < 20) begin @(negedge clk_sys); wc++; end
    exp_rd++; m_bytes++; m_din = 8'hA5;
    chk("idxchg_wait", wc, RL + 1); chk("idxchg_din", 32'(ioctl_din), 32'(m_din));
    chk("idxchg_bytes", 32'(bytes_sent), 32'(m_bytes));
    new_session();

    // checksum streams
    req(25'h0000200, 8'd2, 1'b0);
    req(25'h0000201, 8'd2, 1'b0);
    req(25'h0020000, 8'd2, 1'b0);
`ifdef UPLOAD_CHECKSUM_EN
    chk("csum_0f", 32'(upload_csum), 32'h0F);
`endif
    new_session();
    for (int i = 0; i < 256; i++) req(25'h0001000 + 25'(i), 8'd2, 1'b0);
    chk("bytes_256", 32'(bytes_sent), 256);
`ifdef UPLOAD_CHECKSUM_EN
    chk("csum_80", 32'(upload_csum), 32'h80);
`endif

    // reset mid-fetch
    ioctl_addr = 25'h0000010; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0; exp_rd++; reset_n = 1'b0;
    @(negedge clk_sys);
    chk("rstf_wait", 32'(ioctl_wait), 0); chk("rstf_rd", 32'(mem_rd), 0);
    chk("rstf_din", 32'(ioctl_din), 0); chk("rstf_bytes", 32'(bytes_sent), 0);
    reset_n = 1'b1; cyc(2);

    chk("total_mem_rd", tot_rd, exp_rd);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
